// File: rtl/pci_debug_log_responder.sv
// PCI debug read endpoint: captures per-cycle log words into a circular buffer and
// answers burst reads with a status header followed by destructively popped entries.
module pci_debug_log_responder #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned LOG_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wvalid,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 arvalid,
    input  logic [7:0]           arlen,
    input  logic                 rready,
    output logic [511:0]         rdata,
    output logic                 rvalid,
    output logic                 rlast,
    output logic [LOG_DEPTH:0]   size,
    output logic [31:0]          drop_count
);

    localparam int unsigned         DEPTH     = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0]  SIZE_FULL = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]  SIZE_ONE  = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);
    localparam logic [15:0]         MAGIC     = 16'hDB61;

    typedef enum logic [1:0] {StIdle, StHdr, StFetch, StData} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]   size_q, size_d;
    logic [31:0]          drop_q;
    logic [7:0]           cnt_q, cnt_d;
    logic [LOG_DEPTH:0]   hdr_size_q;
    logic [31:0]          hdr_drop_q;
    logic [WIDTH-1:0]     rd_data_q;
    logic                 empty_q;

    logic full, pop, push, drop, latch_req;

    assign full = (size_q == SIZE_FULL);
    // A data beat only pops when the entry it carries was real (not an empty filler).
    assign pop  = (state_q == StData) && rready && !empty_q;
    // A pop in the same cycle frees a slot, so a full buffer still takes the word.
    assign push = wvalid && (!full || pop);
    assign drop = wvalid && !push;

    assign size       = size_q;
    assign drop_count = drop_q;

    always_comb begin
        size_d = size_q;
        unique case ({push, pop})
            2'b10:   size_d = size_q + SIZE_ONE;
            2'b01:   size_d = size_q - SIZE_ONE;
            default: size_d = size_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rdata     = '0;
        unique case (state_q)
            StIdle: begin
                if (arvalid) begin
                    latch_req = 1'b1;
                    cnt_d     = arlen;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                rvalid        = 1'b1;
                rdata[15:0]   = 16'(hdr_size_q);
                rdata[47:16]  = hdr_drop_q;
                rdata[63:48]  = MAGIC;
                rlast         = (cnt_q == 8'd0);
                if (rready) begin
                    state_d = (cnt_q == 8'd0) ? StIdle : StFetch;
                end
            end
            StFetch: begin
                state_d = StData;
            end
            StData: begin
                rvalid = 1'b1;
                if (!empty_q) begin
                    rdata = 512'(rd_data_q);
                end
                rlast = (cnt_q == 8'd1);
                if (rready) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? StIdle : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            size_q     <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            hdr_size_q <= '0;
            hdr_drop_q <= '0;
            empty_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop && (drop_q != 32'hFFFF_FFFF)) begin
                drop_q <= drop_q + 32'd1;
            end
            if (latch_req) begin
                hdr_size_q <= size_q;
                hdr_drop_q <= drop_q;
            end
            // Emptiness is frozen at fetch; a same-cycle write does not revive the beat.
            if (state_q == StFetch) begin
                empty_q <= (size_q == '0);
            end
        end
    end

    // Storage is never cleared; only the pointers are.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= wdata;
        end
        if (state_q == StFetch) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

endmodule

// File: doc/pci_debug_log_responder.md
Name: pci_debug_log_responder

Overview:
- Tile-side endpoint of the PCI debug read path: captures a stream of per-cycle debug/log words into a circular on-chip buffer.
- Answers PCI debug burst reads with a header beat followed by buffered entries.
- Sits behind the tile's pci_debug_arvalid / pci_debug_arlen / pci_debug_rready inputs and drives the tile's pci_debug_rdata / rvalid / rlast back to the arbiter.
- Reads are destructive: each returned entry is popped.

Parameters:
WIDTH, 512, log word width in bits; must be <= 512; zero-extended into a cache line.
LOG_DEPTH, 10, log2 of buffer entries (DEPTH = 2**LOG_DEPTH).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
wvalid  input  1  capture strobe; one entry per cycle when high
wdata  input  WIDTH  log word to capture
arvalid  input  1  single-cycle read request pulse
arlen  input  8  burst length minus one (total beats = arlen+1, including header)
rready  input  1  read-data accept
rdata  output  512  read beat (cache_line_t)
rvalid  output  1  read beat valid
rlast  output  1  final beat of burst
size  output  LOG_DEPTH+1  registered current occupancy
drop_count  output  32  saturating count of words dropped while full

Behaviour:
- Reset (any cycle, including mid-burst): state IDLE; wr_ptr, rd_ptr, size and drop_count = 0; rvalid = 0, rlast = 0, rdata = 0. Buffer contents are not cleared.
- Capture:
  - wvalid with size < DEPTH, or a data-beat pop in the same cycle: write wdata at wr_ptr, wr_ptr+1 mod DEPTH.
  - wvalid with size == DEPTH and no pop: drop the word; drop_count+1, saturating at 0xFFFFFFFF.
  - Capture runs in every FSM state.
  - size updates next cycle: +1 on write-only, -1 on pop-only, unchanged on write+pop.
- FSM states:
  - IDLE:
    - arvalid -> HDR. Latch arlen into a beat counter; latch the header snapshot of size and drop_count.
    - arvalid in any other state is ignored.
  - HDR:
    - rvalid = 1; rdata[15:0] = size snapshot, zero-extended or truncated to 16 bits.
    - rdata[47:16] = drop_count snapshot; rdata[63:48] = 16'hDB61; all other bits 0.
    - rlast = (arlen == 0).
    - On rvalid&rready: if arlen == 0 -> IDLE, else -> FETCH.
  - FETCH: one cycle. rvalid = 0. Present rd_ptr to the buffer read port (registered read). Sample empty = (size == 0) this cycle; a write in the same cycle does not change the decision. -> DATA.
  - DATA:
    - rvalid = 1; rdata = {zeros, entry} if not empty, else all zeros.
    - rlast = (remaining beat counter == 1).
    - On rvalid&rready: if not empty, pop (rd_ptr+1 mod DEPTH). Decrement the counter. If this was rlast -> IDLE, else -> FETCH.
- Timing:
  - arvalid at cycle t gives the header with rvalid at t+1.
  - Header/data handshake at cycle h gives the next data rvalid at h+2.
  - Throughput is one data beat per two cycles with rready held high.
- Backpressure: while rvalid & !rready, rdata and rlast are held stable and no pop occurs.
- Pointer wrap-around is modulo DEPTH. size distinguishes full from empty when wr_ptr == rd_ptr.
- Entries are returned in capture (FIFO) order.
- Resetting mid-burst abandons the burst; no rlast is issued. The arbiter must be reset with the block.

Test Plan:
- LOG_DEPTH=4. Capture words 0xA,0xB,0xC; arvalid with arlen=3 -> header size=3, drop=0, magic 0xDB61; then 0xA,0xB,0xC; rlast on beat 4; size ends 0.
- LOG_DEPTH=4. Capture 20 words 1..20 with no reads -> size=16, drop_count=4. Read with arlen=16 -> header, then words 1..16.
- Capture one word 0x55; arlen=3 -> header size=1, then 0x55, zero beat, zero beat with rlast; size=0; rd_ptr advanced by 1 only.
- arlen=0 -> exactly one beat (header) with rlast=1 at t+1; FSM returns to IDLE; no pop.
- Hold rready=0 for 5 cycles during a data beat -> rdata/rlast stable, no pop. Continuous wvalid during the read -> size tracks writes minus pops, and a full buffer accepts the write in the pop cycle.
- Assert rst in the middle of a 4-beat burst -> next cycle rvalid=0, size=0, drop_count=0. A new arvalid then yields a header with size=0.
